// File: rtl/ledarray_frame_ctrl_if.sv
// Byte-stream and frame-stream handshake bundle for the LED-array frame controller.
// The controller uses the slave view; the UART/display side uses the master view.
interface ledarray_frame_ctrl_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] frame_data;
  logic        light;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, frame_data, light, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, frame_data, light, out_valid
  );
endinterface

// File: rtl/ledarray_frame_ctrl.sv
// Sync-hunting frame sequencer: UART bytes -> decoded 56-bit glyph frame + backlight bit.
// Optional trailing XOR checksum byte is enabled by defining FRAME_CSUM_EN.
module ledarray_frame_ctrl #(
  parameter int       CLK_FRE    = 50,
  parameter int       TIMEOUT_US = 1000,
  parameter bit [7:0] SYNC_BYTE  = 8'hAA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ledarray_frame_ctrl_if.slave io_bus,
  output logic                 o_err_timeout,
  output logic                 o_err_char,
  output logic                 o_err_csum,
  output logic [7:0]           o_err_cnt
);

  localparam int TIMEOUT_CYC = CLK_FRE * TIMEOUT_US;
  localparam int TCW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_SYNC, S_PAYLOAD, S_CSUM, S_OUT} state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_idx;
  logic [55:0]     r_shadow;
  logic            r_shadow_light;
  logic            r_char_err;
  logic [7:0]      r_xor;
  logic [TCW-1:0]  r_tmo_cnt;
  logic [55:0]     r_frame_data;
  logic            r_light;
  logic            r_out_valid;
  logic            r_err_timeout, r_err_char, r_err_csum;
  logic [7:0]      r_err_cnt;

  logic            w_in_ready, w_accept, w_in_frame;
  logic            w_sync_hit, w_pl_accept, w_last_pl, w_tmo_hit;
  logic            w_frame_end, w_csum_bad, w_char_fin;
  logic            w_set_csum, w_set_char, w_load_out;
  logic [7:0]      w_glyph;
  logic            w_bad_char;
  logic [55:0]     w_shadow_nxt;
  logic            w_light_nxt;

  assign w_in_ready  = (r_state != S_OUT);
  assign w_accept    = io_bus.in_valid && w_in_ready;
  assign w_in_frame  = (r_state == S_PAYLOAD) || (r_state == S_CSUM);
  assign w_sync_hit  = (r_state == S_SYNC) && w_accept && (io_bus.in_data == SYNC_BYTE);
  assign w_pl_accept = (r_state == S_PAYLOAD) && w_accept;
  assign w_last_pl   = w_pl_accept && (r_idx == 3'd6);
  assign w_tmo_hit   = w_in_frame && !w_accept && (r_tmo_cnt == TMO_LAST);
  assign w_char_fin  = r_char_err || (w_last_pl && w_bad_char);

`ifdef FRAME_CSUM_EN
  assign w_frame_end = (r_state == S_CSUM) && w_accept;
  assign w_csum_bad  = w_frame_end && (io_bus.in_data != r_xor);
`else
  assign w_frame_end = w_last_pl;
  assign w_csum_bad  = 1'b0;
`endif

  // Checksum failure outranks a bad character, so a frame raises one pulse at most.
  assign w_set_csum = w_frame_end && w_csum_bad;
  assign w_set_char = w_frame_end && !w_csum_bad && w_char_fin;
  assign w_load_out = w_frame_end && !w_csum_bad && !w_char_fin;

  always_comb begin
    w_glyph    = 8'h00;
    w_bad_char = 1'b0;
    if (r_idx == 3'd0) begin
      w_glyph = {1'b0, io_bus.in_data[6:0]} - 8'h40;
    end else if (r_idx == 3'd1) begin
      w_glyph = io_bus.in_data - 8'd55;
    end else if (io_bus.in_data >= 8'h41) begin
      w_glyph = {3'b000, io_bus.in_data[4:0]} + 8'd9;
    end else if (io_bus.in_data >= 8'h30) begin
      w_glyph = {4'b0000, io_bus.in_data[3:0]};
    end else begin
      w_bad_char = 1'b1;
    end
  end

  // Shadow including the byte being accepted, so the checksum-less build can load idx6 directly.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_light_nxt  = r_shadow_light;
    if (w_pl_accept) begin
      w_shadow_nxt[(6 - r_idx) * 8 +: 8] = w_glyph;
      if (r_idx == 3'd0) w_light_nxt = io_bus.in_data[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_SYNC;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SYNC:    if (w_sync_hit) w_state_nxt = S_PAYLOAD;
      S_PAYLOAD: begin
        if (w_tmo_hit) begin
          w_state_nxt = S_SYNC;
        end else if (w_last_pl) begin
`ifdef FRAME_CSUM_EN
          w_state_nxt = S_CSUM;
`else
          w_state_nxt = w_load_out ? S_OUT : S_SYNC;
`endif
        end
      end
`ifdef FRAME_CSUM_EN
      S_CSUM: begin
        if (w_tmo_hit)        w_state_nxt = S_SYNC;
        else if (w_frame_end) w_state_nxt = w_load_out ? S_OUT : S_SYNC;
      end
`endif
      S_OUT:     if (io_bus.out_ready) w_state_nxt = S_SYNC;
      default:   w_state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx          <= 3'd0;
      r_shadow       <= 56'd0;
      r_shadow_light <= 1'b0;
      r_char_err     <= 1'b0;
      r_xor          <= 8'h00;
    end else if (w_sync_hit || w_tmo_hit) begin
      r_idx          <= 3'd0;
      r_shadow       <= 56'd0;
      r_shadow_light <= 1'b0;
      r_char_err     <= 1'b0;
      r_xor          <= 8'h00;
    end else if (w_pl_accept) begin
      r_idx          <= r_idx + 3'd1;
      r_shadow       <= w_shadow_nxt;
      r_shadow_light <= w_light_nxt;
      r_char_err     <= r_char_err || w_bad_char;
      r_xor          <= r_xor ^ io_bus.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_tmo_cnt <= '0;
    else if (!w_in_frame || w_accept) r_tmo_cnt <= '0;
    else                             r_tmo_cnt <= r_tmo_cnt + TCW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_data <= 56'd0;
      r_light      <= 1'b0;
      r_out_valid  <= 1'b0;
    end else if (w_load_out) begin
      r_frame_data <= w_shadow_nxt;
      r_light      <= w_light_nxt;
      r_out_valid  <= 1'b1;
    end else if (r_out_valid && io_bus.out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_timeout <= 1'b0;
      r_err_char    <= 1'b0;
      r_err_csum    <= 1'b0;
      r_err_cnt     <= 8'h00;
    end else begin
      r_err_timeout <= w_tmo_hit;
      r_err_char    <= w_set_char;
      r_err_csum    <= w_set_csum;
      if ((w_tmo_hit || w_set_char || w_set_csum) && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign io_bus.in_ready   = w_in_ready;
  assign io_bus.frame_data = r_frame_data;
  assign io_bus.light      = r_light;
  assign io_bus.out_valid  = r_out_valid;
  assign o_err_timeout     = r_err_timeout;
  assign o_err_char        = r_err_char;
  assign o_err_csum        = r_err_csum;
  assign o_err_cnt         = r_err_cnt;

endmodule

// File: doc/ledarray_frame_ctrl.md
Name: ledarray_frame_ctrl

Overview:
Frame sequencer between the UART byte receiver and the LED-array display driver. It consumes a ready/valid byte stream and hunts for a sync byte. It then collects a 7-byte payload (plus a checksum when enabled) and decodes ASCII characters into glyph indices. Each validated 56-bit frame plus the backlight bit is presented to the display with a ready/valid handshake. Bad or stalled frames are discarded and counted.

Parameters:
CLK_FRE, 50, clock frequency in MHz
TIMEOUT_US, 1000, inter-byte timeout in microseconds; TIMEOUT_CYC = CLK_FRE*TIMEOUT_US
SYNC_BYTE, 8'hAA, frame start marker

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
in_data  input  8  byte from UART receiver
in_valid  input  1  in_data valid
in_ready  output  1  controller accepts byte this cycle
frame_data  output  56  decoded glyph indices, field0 in [55:48] … field6 in [7:0]
light  output  1  backlight enable for the frame
out_valid  output  1  frame_data/light hold a new frame
out_ready  input  1  display has taken the frame
err_timeout  output  1  1-cycle pulse, frame aborted by timeout
err_char  output  1  1-cycle pulse, frame held an illegal character
err_csum  output  1  1-cycle pulse, checksum mismatch
err_cnt  output  8  total error pulses, saturates at 255

Behaviour:
- Reset: state S_SYNC; frame_data=0, light=0, out_valid=0, err_*=0, err_cnt=0, in_ready=1, shadow registers 0.
- Byte accept = in_valid && in_ready. in_ready=1 in S_SYNC/S_PAYLOAD/S_CSUM, 0 in S_OUT.
- S_SYNC: accepted bytes not equal to SYNC_BYTE are dropped silently (no error). SYNC_BYTE -> S_PAYLOAD, byte index=0, char-error flag cleared, running XOR cleared.
- S_PAYLOAD: each accepted byte b is decoded into shadow field[idx] and XORed into the running sum. SYNC_BYTE inside the payload is plain data, not a resync.
  - idx0: glyph={1'b0,b[6:0]}-8'h40 (mod 256); shadow light=b[7].
  - idx1: glyph=b-8'd55 (mod 256).
  - idx2..6: b>=8'h41 -> {3'b000,b[4:0]}+8'd9; else b>=8'h30 -> {4'b0000,b[3:0]}; else glyph=0 and char-error flag set.
  - After idx6 is accepted: -> S_CSUM (FRAME_CSUM_EN) or frame-end evaluation.
- S_CSUM: next accepted byte is compared against the running XOR, then frame-end evaluation.
- Frame-end evaluation, in the cycle after the last byte is accepted:
  - Checksum mismatch: err_csum pulse, -> S_SYNC.
  - Else char-error flag set: err_char pulse, -> S_SYNC.
  - Else: shadow copied to frame_data/light, out_valid=1, -> S_OUT.
  - A frame raises at most one error pulse; csum has priority over char.
- S_OUT: out_valid held high and frame_data stable until out_valid&&out_ready. out_valid falls the next cycle and the state returns to S_SYNC.
- Outside a valid handshake, frame_data/light keep the last good frame. Discarded frames never alter them.
- Timeout: a cycle counter runs in S_PAYLOAD/S_CSUM, cleared on each accept and on entry. On reaching TIMEOUT_CYC-1 with no accept that cycle: err_timeout pulse, -> S_SYNC, shadow discarded. An accept on that same cycle wins and the counter clears. No timeout in S_SYNC or S_OUT.
- err_cnt += 1 per err_* pulse, saturating at 8'hFF.
- Reset mid-frame: immediate return to the reset values above. The partial frame is lost and no error is counted.

Optional Feature:
FRAME_CSUM_EN
- Defined: the frame is SYNC_BYTE, 7 payload bytes, then 1 checksum byte equal to the XOR of the 7 raw payload bytes. Mismatch raises err_csum.
- Undefined: no checksum byte. The frame is evaluated right after payload idx6, S_CSUM is not built, and err_csum is tied 0.

Test Plan:
1. FRAME_CSUM_EN defined; send AA C1 4B 30 39 41 5A 35 AD -> one cycle after AD is accepted: out_valid=1, frame_data=56'h01_14_00_09_0A_23_05, light=1; no errors.
2. Same frame with checksum byte AC -> single err_csum pulse, err_cnt=1, out_valid stays 0, frame_data unchanged from the prior value.
3. CLK_FRE=50, TIMEOUT_US=1 (TIMEOUT_CYC=50); send AA C1 4B 30, then idle -> err_timeout pulses 50 cycles after the last accept, state S_SYNC. A following full frame is then accepted normally.
4. Payload byte idx3=8'h20 -> err_char pulse at frame end, no out_valid. With an additional bad checksum, only err_csum pulses.
5. out_ready=0 for 20 cycles after the frame, next byte stream on in_valid -> out_valid and frame_data held, in_ready=0 throughout. After out_ready=1 the handshake completes, out_valid drops next cycle, and incoming bytes 55 12 ahead of AA are dropped without error.
6. Assert rst_n low after 4 payload bytes, release, send a full frame -> frame decodes correctly, err_cnt=0.
